// File: rtl/nvram_backup_ctrl.sv
// NVRAM backup sequencer: streams one save slot between the NVRAM buffer and the
// HPS SD sector interface, with dirty tracking, autosave and size-checked autoload.
module nvram_backup_ctrl #(
    parameter int SECTORS_LOG2 = 6,
    parameter int SLOT_W       = 2,
    parameter int LBA_W        = 32,
    parameter int TMO_W        = 24
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    downloading,
    input  logic                    img_mounted,
    input  logic                    img_readonly,
    input  logic [63:0]             img_size,
    input  logic                    nvram_we,
    input  logic                    osd_status,
    input  logic                    autosave,
    input  logic                    load_req,
    input  logic                    save_req,
    input  logic [SLOT_W-1:0]       slot,
    input  logic                    sd_ack,
    output logic [LBA_W-1:0]        sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    output logic [SECTORS_LOG2-1:0] sector,
    output logic                    bk_ena,
    output logic                    bk_busy,
    output logic                    bk_loading,
    output logic                    bk_pending,
    output logic                    bk_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0]        TMO_MAX     = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0]        TMO_ZERO    = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]        TMO_ONE     = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [SECTORS_LOG2-1:0] SECTOR_LAST = {SECTORS_LOG2{1'b1}};
    localparam logic [SECTORS_LOG2-1:0] SECTOR_ZERO = {SECTORS_LOG2{1'b0}};
    localparam logic [SECTORS_LOG2-1:0] SECTOR_ONE  = {{(SECTORS_LOG2-1){1'b0}}, 1'b1};

    state_t                  state_r, state_s;
    logic [SLOT_W-1:0]       slot_lat_r, slot_lat_s;
    logic [SECTORS_LOG2-1:0] sector_r, sector_s;
    logic [TMO_W-1:0]        tmo_r, tmo_s, tmo_inc_s;
    logic                    rd_r, rd_s, wr_r, wr_s;
    logic                    busy_r, busy_s, loading_r, loading_s;
    logic                    error_r, error_s, pending_r, pending_s;
    logic                    ena_r, ena_s, done_s;
    logic                    load_d_r, save_d_r, dl_d_r, osd_d_r, ack_d_r;
    logic                    load_rise_s, save_rise_s, dl_rise_s, dl_fall_s;
    logic                    osd_trig_s, osd_rise_s, ack_rise_s, ack_fall_s;
    logic                    size_ok_s, trig_load_s, trig_any_s, start_s;
    logic                    tmo_max_s, last_s, pend_set_s;
    logic [63:0]             slot_bytes_s;

    assign load_rise_s  = load_req & ~load_d_r;
    assign save_rise_s  = save_req & ~save_d_r;
    assign dl_rise_s    = downloading & ~dl_d_r;
    assign dl_fall_s    = ~downloading & dl_d_r;
    assign osd_trig_s   = osd_status & autosave & pending_r;
    assign osd_rise_s   = osd_trig_s & ~osd_d_r;
    assign ack_rise_s   = sd_ack & ~ack_d_r;
    assign ack_fall_s   = ~sd_ack & ack_d_r;

    // Image must cover every byte up to the end of the selected slot.
    assign slot_bytes_s = (64'(slot) + 64'd1) << (SECTORS_LOG2 + 9);
    assign size_ok_s    = (img_size >= slot_bytes_s);
    assign trig_load_s  = load_rise_s | (dl_fall_s & size_ok_s);
    assign trig_any_s   = trig_load_s | save_rise_s | osd_rise_s;
    assign start_s      = (state_r == ST_IDLE) & ena_r & trig_any_s;

    assign tmo_inc_s    = tmo_r + TMO_ONE;
    assign tmo_max_s    = (tmo_inc_s == TMO_MAX);
    assign last_s       = (sector_r == SECTOR_LAST);
    assign pend_set_s   = nvram_we & ena_r & ~osd_status & ~busy_r;

    assign sd_lba       = LBA_W'({slot_lat_r, sector_r});
    assign sd_rd        = rd_r;
    assign sd_wr        = wr_r;
    assign sector       = sector_r;
    assign bk_ena       = ena_r;
    assign bk_busy      = busy_r;
    assign bk_loading   = loading_r;
    assign bk_pending   = pending_r;
    assign bk_error     = error_r;

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; timeout takes precedence over a coincident ack edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_REQ;
                else         state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (tmo_max_s)       state_s = ST_IDLE;
                else if (ack_rise_s) state_s = ST_ACK;
                else                 state_s = ST_REQ;
            end
            ST_ACK: begin
                if (tmo_max_s)       state_s = ST_IDLE;
                else if (ack_fall_s) state_s = last_s ? ST_IDLE : ST_REQ;
                else                 state_s = ST_ACK;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and transfer bookkeeping.
    always_comb begin
        slot_lat_s = slot_lat_r;
        sector_s   = sector_r;
        tmo_s      = tmo_r;
        rd_s       = rd_r;
        wr_s       = wr_r;
        busy_s     = busy_r;
        loading_s  = loading_r;
        error_s    = error_r;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tmo_s = TMO_ZERO;
                if (start_s) begin
                    slot_lat_s = slot;
                    sector_s   = SECTOR_ZERO;
                    busy_s     = 1'b1;
                    error_s    = 1'b0;
                    loading_s  = trig_load_s;
                    rd_s       = trig_load_s;
                    wr_s       = ~trig_load_s;
                end else begin
                    rd_s = 1'b0;
                    wr_s = 1'b0;
                end
            end
            ST_REQ, ST_ACK: begin
                if (tmo_max_s) begin
                    tmo_s     = TMO_ZERO;
                    rd_s      = 1'b0;
                    wr_s      = 1'b0;
                    busy_s    = 1'b0;
                    loading_s = 1'b0;
                    error_s   = 1'b1;
                end else if ((state_r == ST_REQ) && ack_rise_s) begin
                    tmo_s = TMO_ZERO;
                    rd_s  = 1'b0;
                    wr_s  = 1'b0;
                end else if ((state_r == ST_ACK) && ack_fall_s) begin
                    tmo_s = TMO_ZERO;
                    if (last_s) begin
                        busy_s    = 1'b0;
                        loading_s = 1'b0;
                        done_s    = 1'b1;
                    end else begin
                        sector_s = sector_r + SECTOR_ONE;
                        rd_s     = loading_r;
                        wr_s     = ~loading_r;
                    end
                end else begin
                    tmo_s = tmo_inc_s;
                end
            end
            default: begin
                tmo_s     = TMO_ZERO;
                rd_s      = 1'b0;
                wr_s      = 1'b0;
                busy_s    = 1'b0;
                loading_s = 1'b0;
            end
        endcase

        if (done_s)          pending_s = 1'b0;
        else if (pend_set_s) pending_s = 1'b1;
        else                 pending_s = pending_r;

        if (downloading & img_mounted & ~img_readonly) ena_s = 1'b1;
        else if (dl_rise_s)                            ena_s = 1'b0;
        else                                           ena_s = ena_r;
    end

    // Output, bookkeeping and edge-history registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            slot_lat_r <= {SLOT_W{1'b0}};
            sector_r   <= SECTOR_ZERO;
            tmo_r      <= TMO_ZERO;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            busy_r     <= 1'b0;
            loading_r  <= 1'b0;
            error_r    <= 1'b0;
            pending_r  <= 1'b0;
            ena_r      <= 1'b0;
            load_d_r   <= 1'b1;
            save_d_r   <= 1'b1;
            dl_d_r     <= 1'b1;
            osd_d_r    <= 1'b1;
            ack_d_r    <= 1'b0;
        end else begin
            slot_lat_r <= slot_lat_s;
            sector_r   <= sector_s;
            tmo_r      <= tmo_s;
            rd_r       <= rd_s;
            wr_r       <= wr_s;
            busy_r     <= busy_s;
            loading_r  <= loading_s;
            error_r    <= error_s;
            pending_r  <= pending_s;
            ena_r      <= ena_s;
            load_d_r   <= load_req;
            save_d_r   <= save_req;
            dl_d_r     <= downloading;
            osd_d_r    <= osd_trig_s;
            ack_d_r    <= sd_ack;
        end
    end

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Directed/randomised bench for nvram_backup_ctrl: a host model answers each
// sector request with random latency and checks against expected slot/sector sequences.
module tb_nvram_backup_ctrl;

    localparam int SL2   = 6;
    localparam int NSEC  = 1 << SL2;
    localparam int SLOTB = NSEC * 512;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        downloading, img_mounted, img_readonly;
    logic [63:0] img_size;
    logic        nvram_we, osd_status, autosave, load_req, save_req;
    logic [1:0]  slot;
    logic        sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic [5:0]  sector;
    logic        bk_ena, bk_busy, bk_loading, bk_pending, bk_error;

    int total = 0;
    int bad   = 0;
    int slot_change_at = -1;
    int save_drop_at   = -1;
    int save_rise_at   = -1;
    bit exp_pend = 1'b0;
    bit exp_ena  = 1'b0;

    nvram_backup_ctrl #(
        .SECTORS_LOG2(SL2), .SLOT_W(2), .LBA_W(32), .TMO_W(4)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .downloading(downloading),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .nvram_we(nvram_we), .osd_status(osd_status), .autosave(autosave),
        .load_req(load_req), .save_req(save_req), .slot(slot), .sd_ack(sd_ack),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sector(sector),
        .bk_ena(bk_ena), .bk_busy(bk_busy), .bk_loading(bk_loading),
        .bk_pending(bk_pending), .bk_error(bk_error)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nv_write();
        exp_pend = exp_pend | (exp_ena & !osd_status & !bk_busy);
        nvram_we = 1'b1; tick();
        nvram_we = 1'b0; tick();
    endtask

    // Mount an image during a download, then end the download.
    task automatic download_cycle(input logic [63:0] sz, input logic [1:0] sl);
        img_size = sz; slot = sl;
        downloading = 1'b1; tick();
        img_mounted = 1'b1; tick();
        img_mounted = 1'b0; tick();
        exp_ena = !img_readonly;
        downloading = 1'b0; tick();
    endtask

    // Host side: answer `upto` sector requests, expecting slot `sl` in mode `ld`.
    task automatic serve(input bit ld, input int sl, input int upto);
        int waited;
        for (int i = 0; i < upto; i++) begin
            waited = 0;
            while (!(sd_rd | sd_wr) && waited < 30) begin
                tick();
                waited++;
            end
            chk("req_seen", sd_rd | sd_wr, 1'b1);
            if (!(sd_rd | sd_wr)) return;
            chk("rd", sd_rd, ld);
            chk("wr", sd_wr, !ld);
            chk("lba", sd_lba, 64'(sl * NSEC + i));
            chk("sector", sector, 64'(i));
            chk("busy", bk_busy, 1'b1);
            chk("loading", bk_loading, ld);
            if (i == slot_change_at) slot = 2'd0;
            if (i == save_drop_at) save_req = 1'b0;
            if (i == save_rise_at) save_req = 1'b1;
            repeat ($urandom_range(0, 3)) tick();
            chk("req_held", sd_rd | sd_wr, 1'b1);
            sd_ack = 1'b1; tick();
            chk("req_drop", sd_rd | sd_wr, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
            sd_ack = 1'b0; tick();
            if (i == NSEC - 1) begin
                chk("busy_end", bk_busy, 1'b0);
                chk("loading_end", bk_loading, 1'b0);
                exp_pend = 1'b0;
            end else begin
                chk("busy_mid", bk_busy, 1'b1);
            end
        end
    endtask

    initial begin
        int n;
        int sl5;
        bit any_req;
        bit exp_auto;

        reset = 1'b1; downloading = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        img_size = 64'd0; nvram_we = 1'b0; osd_status = 1'b0; autosave = 1'b0;
        load_req = 1'b0; save_req = 1'b0; slot = 2'd0; sd_ack = 1'b0;
        #3;
        chk("rst_rd", sd_rd, 1'b0);
        chk("rst_wr", sd_wr, 1'b0);
        chk("rst_busy", bk_busy, 1'b0);
        chk("rst_loading", bk_loading, 1'b0);
        chk("rst_pending", bk_pending, 1'b0);
        chk("rst_error", bk_error, 1'b0);
        chk("rst_ena", bk_ena, 1'b0);
        chk("rst_sector", sector, 64'd0);
        chk("rst_lba", sd_lba, 64'd0);
        repeat (2) tick();
        reset = 1'b0; tick();

        // Autoload of slot 0 after a download with an exactly sized image.
        img_size = 64'd32768; slot = 2'd0;
        downloading = 1'b1; tick();
        img_mounted = 1'b1; tick();
        img_mounted = 1'b0; tick();
        exp_ena = 1'b1;
        chk("ena_set", bk_ena, exp_ena);
        chk("no_start_while_dl", bk_busy, 1'b0);
        downloading = 1'b0; tick();
        chk("auto_busy", bk_busy, 1'b1);
        chk("auto_loading", bk_loading, 1'b1);
        serve(1'b1, 0, NSEC);
        chk("auto_pend", bk_pending, exp_pend);

        // Save to slot 2; slot input changes mid-transfer.
        nv_write();
        chk("pend_set", bk_pending, exp_pend);
        slot = 2'd2; save_req = 1'b1; tick();
        chk("save_busy", bk_busy, 1'b1);
        slot_change_at = 30;
        serve(1'b0, 2, NSEC);
        slot_change_at = -1;
        save_req = 1'b0; tick();
        chk("save_pend_clr", bk_pending, exp_pend);
        chk("save_err", bk_error, 1'b0);

        // Dirty tracking and OSD-triggered autosave.
        osd_status = 1'b1;
        nv_write();
        chk("pend_osd_block", bk_pending, exp_pend);
        osd_status = 1'b0; tick();
        nv_write();
        chk("pend_set2", bk_pending, exp_pend);
        autosave = 1'b1; osd_status = 1'b1; tick();
        chk("autosave_busy", bk_busy, 1'b1);
        serve(1'b0, 0, NSEC);
        chk("autosave_pend", bk_pending, exp_pend);
        osd_status = 1'b0; tick();
        nv_write();
        autosave = 1'b0; osd_status = 1'b1;
        repeat (5) tick();
        chk("no_autosave", bk_busy, 1'b0);
        chk("pend_kept", bk_pending, exp_pend);
        osd_status = 1'b0; tick();

        // Timeout with no acknowledge.
        save_req = 1'b1; tick();
        chk("tmo_start_wr", sd_wr, 1'b1);
        n = 0;
        while (bk_busy && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'd15);
        chk("tmo_wr", sd_wr, 1'b0);
        chk("tmo_rd", sd_rd, 1'b0);
        chk("tmo_err", bk_error, 1'b1);
        chk("tmo_pend", bk_pending, exp_pend);
        save_req = 1'b0;
        repeat (3) tick();
        chk("tmo_err_hold", bk_error, 1'b1);
        load_req = 1'b1; tick();
        chk("err_clr", bk_error, 1'b0);
        chk("load_rd", sd_rd, 1'b1);
        serve(1'b1, 0, NSEC);
        load_req = 1'b0; tick();
        chk("load_pend", bk_pending, exp_pend);

        // Simultaneous load/save, busy save edge, reset mid-transfer.
        sl5 = $urandom_range(0, 3);
        slot = 2'(sl5);
        load_req = 1'b1; save_req = 1'b1; tick();
        chk("prio_rd", sd_rd, 1'b1);
        chk("prio_wr", sd_wr, 1'b0);
        save_drop_at = 2; save_rise_at = 5;
        serve(1'b1, sl5, 10);
        save_drop_at = -1; save_rise_at = -1;
        n = 0;
        while (!sd_rd && n < 30) begin
            tick();
            n++;
        end
        chk("sec10_rd", sd_rd, 1'b1);
        chk("sec10_sector", sector, 64'd10);
        chk("sec10_lba", sd_lba, 64'(sl5 * NSEC + 10));
        #2;
        reset = 1'b1;
        #1;
        exp_ena = 1'b0; exp_pend = 1'b0;
        chk("arst_rd", sd_rd, 1'b0);
        chk("arst_busy", bk_busy, 1'b0);
        chk("arst_loading", bk_loading, 1'b0);
        chk("arst_sector", sector, 64'd0);
        chk("arst_ena", bk_ena, exp_ena);
        repeat (2) tick();
        reset = 1'b0;
        any_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            any_req = any_req | sd_rd | sd_wr | bk_busy;
        end
        chk("post_rst_quiet", any_req, 1'b0);
        load_req = 1'b0; save_req = 1'b0; tick();

        // Read-only image: nothing is accepted.
        img_readonly = 1'b1;
        download_cycle(64'd32768, 2'd0);
        chk("ro_ena", bk_ena, exp_ena);
        chk("ro_busy", bk_busy, 1'b0);
        load_req = 1'b1; tick(); tick();
        chk("ro_load", bk_busy, 1'b0);
        load_req = 1'b0; tick();
        nv_write();
        chk("ro_pend", bk_pending, exp_pend);

        // Autoload size check around the slot-1 boundary.
        img_readonly = 1'b0;
        for (int t = 0; t < 3; t++) begin
            logic [63:0] sz;
            sz = (t == 0) ? 64'd16384 : ((t == 1) ? 64'd65535 : 64'd65536);
            download_cycle(sz, 2'd1);
            exp_auto = (sz >= 64'(2 * SLOTB));
            chk("size_ena", bk_ena, exp_ena);
            chk("size_auto", bk_busy, exp_auto);
            if (exp_auto) serve(1'b1, 1, NSEC);
            else begin
                repeat (4) tick();
                chk("size_skip", bk_busy, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nvram_backup_ctrl.md
Name: nvram_backup_ctrl

Overview:
Parametrised backup-RAM save/load sequencer between the core's NVRAM dual-port buffer and the HPS SD sector interface. Transfers a fixed-size NVRAM image as 2^SECTORS_LOG2 consecutive 512-byte sectors. Adds selectable save slots, dirty tracking, OSD-triggered autosave, size-checked autoload after cartridge download, and an ack timeout with an error flag. Sits in the emu top level next to hps_io and the NVRAM dpram; `sector` drives the upper dpram port-B address bits.

Parameters:
SECTORS_LOG2, 6, log2 of sectors per slot (64 sectors = 32 KB)
SLOT_W, 2, slot select width (2^SLOT_W slots)
LBA_W, 32, sd_lba width
TMO_W, 24, timeout counter width; abort when the counter reaches all-ones

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
downloading  in  1  cartridge download in progress
img_mounted  in  1  save image mount strobe
img_readonly  in  1  mounted image is read-only
img_size  in  64  mounted image size in bytes
nvram_we  in  1  core write to backup RAM
osd_status  in  1  OSD open
autosave  in  1  autosave enable
load_req  in  1  load request, rising edge
save_req  in  1  save request, rising edge
slot  in  SLOT_W  slot select; latched at transfer start
sd_ack  in  1  HPS sector acknowledge
sd_lba  out  LBA_W  sector address
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
sector  out  SECTORS_LOG2  current sector index within slot
bk_ena  out  1  writable save image present
bk_busy  out  1  transfer active
bk_loading  out  1  load active; holds core in reset
bk_pending  out  1  unsaved NVRAM changes
bk_error  out  1  last transfer timed out

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0; request edge-history registers reset to 1, so a level already high produces no edge.
- bk_ena: cleared on the rising edge of downloading; set on any cycle with downloading & img_mounted & ~img_readonly.
- bk_pending: set on nvram_we & bk_ena & ~osd_status & ~bk_busy; cleared on successful completion of a save or a load; a timeout leaves it unchanged.
- Triggers, in priority order, accepted only in IDLE with bk_ena=1:
  1. Rising edge of load_req: load.
  2. Falling edge of downloading with img_size >= (slot+1) << (SECTORS_LOG2+9): autoload. If undersized, skipped silently.
  3. Rising edge of save_req: save.
  4. Rising edge of (osd_status & autosave & bk_pending): save.
- Simultaneous triggers: highest priority only; the others are discarded. Edges arriving while busy or while bk_ena=0 are discarded, not queued.
- States: IDLE -> REQ -> ACK -> (REQ | IDLE).
- Start: on the clock edge after the trigger cycle:
  - slot latched; sector=0; bk_busy=1; bk_error=0.
  - bk_loading = load; sd_rd = load; sd_wr = ~load.
  - State REQ.
- sd_lba = zero-extended {slot_latched, sector}, i.e. slot*2^SECTORS_LOG2 + sector. Valid whenever bk_busy=1.
- REQ: on sd_ack rising (registered previous ack) -> sd_rd=sd_wr=0, state ACK.
- ACK: on sd_ack falling:
  - If sector is all-ones: bk_busy=0, bk_loading=0, pending cleared, state IDLE.
  - Otherwise: sector+1, reassert the same rd/wr, state REQ.
- Timeout:
  - Counter clears at each state entry and increments in REQ and ACK.
  - When it reaches all-ones: sd_rd=sd_wr=0, bk_busy=0, bk_loading=0, bk_error=1, state IDLE.
  - bk_error holds until the next accepted trigger.
- Reset mid-transfer: immediate, asynchronous return to reset values. Any sector in flight is abandoned, with no further rd/wr.
- sd_rd and sd_wr are never both 1.

Test Plan:
1. Writable image mounted during download, img_size=32768, slot=0; downloading falls -> autoload: sd_rd pulses at lba 0..63 with sector tracking, bk_loading=1 throughout, bk_busy and bk_loading drop the cycle after the 64th ack falls.
2. save_req rises with slot=2 -> sd_wr at lba 128..191; slot changed to 0 mid-transfer has no effect; bk_pending=0 at completion.
3. nvram_we pulse with osd_status=0 -> bk_pending=1. osd_status rises with autosave=1 -> save at lba 0. Repeat with autosave=0 -> no transfer, pending stays 1.
4. TMO_W=4, sd_ack held 0 after a save start -> after 15 cycles in REQ: sd_wr=0, bk_error=1, bk_busy=0, bk_pending still 1. Next load_req clears bk_error.
5. load_req and save_req rise in the same cycle -> load only. save_req edge at sector 5 is ignored. Reset asserted at sector 10 -> outputs 0 without waiting for a clock, and no request appears after release.
6. img_readonly=1 -> bk_ena=0 and all requests ignored. Writable image with img_size=16384 and slot=1 -> autoload skipped, bk_busy stays 0.
